rr_arbiter8: RTL
================

// Module: rr_arbiter8
// PURPOSE
//  Round-robin arbiter sharing one downstream resource among 8 requesters.
//  - Grant is registered one-hot; its 3-bit index comes from the team's 8-to-3 encoder.
//  - A grant is held while its requester keeps requesting, up to MAX_HOLD cycles.
//  - Fairness is by a rotating priority pointer.
// PARAMETERS
//  MAX_HOLD  16  max consecutive cycles one grant is held (>=2)
//  HOLD_EN   1   1: enforce MAX_HOLD; 0: hold until request drops
// PORTS
//  iClk       in   1  clock, rising edge
//  iRst       in   1  asynchronous reset, active-high
//  iReq       in   8  request per requester; bit i = requester i
//  oGrant     out  8  registered one-hot grant; 0 when idle
//  oGrantIdx  out  3  binary index of the set bit of oGrant; 0 when idle
//  oValid     out  1  1 while any grant is active (== |oGrant)
// BEHAVIOUR
//  Reset (async, immediate, also mid-grant):
//  - oGrant=0, oGrantIdx=0, oValid=0.
//  - State=IDLE, pointer=0, hold counter=0.
//  Arbitration function ARB(mask):
//  - Pick the first set bit of iReq&mask.
//  - Search starts at the pointer and goes upward, wrapping from 7 to 0.
//  States:
//  - IDLE:
//    - iReq==0: stay in IDLE.
//    - Otherwise at the next edge: grant ARB(8'hFF), go to GRANT, counter=0.
//    - Latency: request to grant is 1 cycle.
//  - GRANT (granted index g):
//    - Hold while iReq[g]==1 and not hold-limit; counter increments each cycle.
//    - Hold-limit = HOLD_EN && counter==MAX_HOLD-1.
//  - Release (iReq[g]==0 or hold-limit), at that edge:
//    - pointer <= g+1 (mod 8).
//    - New grant = ARB with bit g masked out, registered at the same edge.
//      No idle gap between grants; counter=0.
//    - No other request: oGrant=0, go to IDLE.
//    - A force-released requester still requesting is eligible again from IDLE.
//  Boundaries:
//  - Requests appearing or dropping in the same cycle as a release are sampled at that edge.
//  - Pointer wrap: g=7 gives pointer=0.
//  - oGrant is never multi-hot; a grant never changes except at release.
//  - iReq bits for other requesters are ignored while a grant is held.
//  - Counter width is $clog2(MAX_HOLD); it never exceeds MAX_HOLD-1.
// STRUCTURE
//  - Shared package: constant N_REQ=8, IDX_W=3, state enum {IDLE, GRANT}.
//  - One sub-module: encoder83 (iData=oGrant, oData=oGrantIdx).
//    Its contract: oData = position of the single set bit of iData.
//  - Local logic: rotate-mask priority pick, pointer register, hold counter, 2-state FSM.
// TESTING
//  1. Reset:
//     - Assert iRst with iReq=8'hFF.
//     - Expect oGrant=0, oValid=0, oGrantIdx=0 throughout.
//  2. Single request:
//     - iReq=8'h08 from cycle 0.
//     - Expect oGrant=8'h08, oGrantIdx=3 at cycle 1.
//     - Drop at cycle 4; expect oGrant=0 at cycle 5.
//  3. Round robin:
//     - iReq=8'hFF; each grant held 1 cycle by dropping the granted bit once.
//     - Expect grant order 0,1,2,...,7,0 with no idle cycles.
//  4. Wrap:
//     - pointer=6 (after serving 5), iReq=8'h21.
//     - Expect grant 0 before 5.
//  5. Hold limit, HOLD_EN=1, MAX_HOLD=4:
//     - iReq=8'h03 constant.
//     - Expect requester 0 for 4 cycles, then requester 1 for 4 cycles, then 0 again.
//     - With iReq=8'h01 only: 4 cycles granted, 1 idle, regrant.
//  6. Async reset mid-grant:
//     - Assert iRst between edges during a GRANT.
//     - Expect oGrant=0 before the next edge; after release, grant restarts from pointer 0.

Source files
------------

// File: rtl/rr_arbiter8_pkg.sv
// Shared constants, FSM state type and the rotating-priority pick used by the
// 8-way round-robin arbiter.
package rr_arbiter8_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic {IDLE, GRANT} state_t;

   // The search starts at i_ptr and moves upward, wrapping from the top bit to 0.
   // Rotate right so i_ptr lands on bit 0, isolate the lowest set bit, then rotate back.
   function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] i_req,
                                                input logic [IDX_W-1:0] i_ptr);
      logic [2*N_REQ-1:0] w_dbl;
      logic [N_REQ-1:0]   w_rot;
      logic [N_REQ-1:0]   w_lsb;
      w_dbl = {i_req, i_req} >> i_ptr;
      w_rot = w_dbl[N_REQ-1:0];
      w_lsb = w_rot & (~w_rot + N_REQ'(1));
      w_dbl = {w_lsb, w_lsb} << i_ptr;
      return w_dbl[2*N_REQ-1:N_REQ];
   endfunction

endpackage

// File: rtl/rr_arbiter8_encoder83.sv
// 8-to-3 encoder: returns the position of the single set bit of iData.
// An all-zero input gives 0.
module encoder83
   import rr_arbiter8_pkg::*;
(
   input  logic [N_REQ-1:0] iData,
   output logic [IDX_W-1:0] oData
);

   // With a one-hot input, OR-ing the indices of the set bits yields its position.
   always_comb begin
      oData = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (iData[i]) oData = oData | IDX_W'(i);
      end
   end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a registered one-hot grant, a
// rotating priority pointer and an optional limit on how long a grant is held.
module rr_arbiter8
   import rr_arbiter8_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter bit HOLD_EN  = 1'b1
)(
   input  logic             iClk,
   input  logic             iRst,
   input  logic [N_REQ-1:0] iReq,
   output logic [N_REQ-1:0] oGrant,
   output logic [IDX_W-1:0] oGrantIdx,
   output logic             oValid
);

   localparam int             CNT_W    = $clog2(MAX_HOLD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

   state_t             r_state;
   logic [N_REQ-1:0]   r_grant;
   logic [IDX_W-1:0]   r_ptr;
   logic [CNT_W-1:0]   r_cnt;

   state_t             w_state_nxt;
   logic [N_REQ-1:0]   w_grant_nxt;
   logic [IDX_W-1:0]   w_ptr_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [IDX_W-1:0]   w_idx;
   logic [IDX_W-1:0]   w_idx_inc;
   logic [N_REQ-1:0]   w_req_others;
   logic               w_req_held;
   logic               w_hold_limit;

   encoder83 u_enc (
      .iData (r_grant),
      .oData (w_idx)
   );

   assign w_idx_inc    = w_idx + IDX_W'(1);
   assign w_req_others = iReq & ~r_grant;
   assign w_req_held   = |(iReq & r_grant);
   assign w_hold_limit = HOLD_EN && (r_cnt == CNT_LAST);

   // NOTE: every next-state signal gets its default before the case, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (|iReq) begin
               w_grant_nxt = rr_pick(iReq, r_ptr);
               w_cnt_nxt   = '0;
               w_state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (w_req_held && !w_hold_limit) begin
               // Saturates only when the limit is disabled; otherwise release comes first.
               if (r_cnt != CNT_LAST) w_cnt_nxt = r_cnt + CNT_W'(1);
            end else begin
               w_ptr_nxt   = w_idx_inc;
               w_grant_nxt = rr_pick(w_req_others, w_idx_inc);
               w_cnt_nxt   = '0;
               w_state_nxt = (|w_req_others) ? GRANT : IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of the order the processes run in.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_ptr   <= w_ptr_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign oGrant    = r_grant;
   assign oGrantIdx = w_idx;
   assign oValid    = |r_grant;

endmodule
